// File: rtl/pipeline_scoreboard.sv
// Issue controller: per-register pending-write countdown scoreboard between decode and ID/EX.
// Optional stall statistics counter enabled by SCOREBOARD_STATS_EN.
module pipeline_scoreboard #(
    parameter int REG_AW  = 3,
    parameter int OPC_W   = 4,
    parameter int WB_DIST = 3,
    parameter int CNT_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPC_W-1:0]      opcode,
    input  logic [REG_AW-1:0]     r1_decode,
    input  logic [REG_AW-1:0]     r2_decode,
    input  logic [REG_AW-1:0]     w_decode,
    input  logic                  decode_valid,
    input  logic                  flush,
    input  logic                  mem_wait,
    output logic                  stall,
    output logic                  issue,
    output logic [2**REG_AW-1:0]  busy_mask
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    localparam int NREG = 2**REG_AW;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             rd1, rd2, rdw, wr;
    logic             hazard;

    always_comb begin
        rd1 = 1'b0;
        rd2 = 1'b0;
        rdw = 1'b0;
        wr  = 1'b0;
        case (opcode)
            OPC_W'(1), OPC_W'(2), OPC_W'(3), OPC_W'(4),
            OPC_W'(5), OPC_W'(6), OPC_W'(7), OPC_W'(8): begin
                rd1 = 1'b1;
                rd2 = 1'b1;
                wr  = 1'b1;
            end
            OPC_W'(9), OPC_W'(10): begin
                rd1 = 1'b1;
                wr  = 1'b1;
            end
            OPC_W'(11): begin
                rd1 = 1'b1;
                rdw = 1'b1;
            end
            OPC_W'(12): rd1 = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    // busy_mask[0] is always 0, so R0 operands never raise a hazard
    assign hazard = (rd1 & busy_mask[r1_decode]) |
                    (rd2 & busy_mask[r2_decode]) |
                    (rdw & busy_mask[w_decode]);

    assign stall = rst_n & decode_valid & hazard & ~flush;
    assign issue = rst_n & decode_valid & ~hazard & ~flush & ~mem_wait;

    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!mem_wait && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            if (issue && wr && w_decode == REG_AW'(r)) begin
                cnt_d[r] = CNT_W'(WB_DIST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Sequential issue controller for the 5-stage core. It sits between decode and the ID/EX pipeline register.
- It replaces per-stage write-address comparison with a per-register pending-write countdown scoreboard.
- It decides each cycle whether the decoded instruction issues, stalls, or is dropped (flush). It tracks in-flight destinations until writeback.

Parameters:
- REG_AW, 3, register address width (8 registers; R0 hardwired zero, never tracked)
- OPC_W, 4, opcode width
- WB_DIST, 3, cycles from issue until the destination is readable in decode; 1..(2^CNT_W-1)
- CNT_W, 2, per-register countdown width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- opcode  input  OPC_W  opcode of instruction in decode
- r1_decode  input  REG_AW  source register 1
- r2_decode  input  REG_AW  source register 2
- w_decode  input  REG_AW  destination (or store-data source for opcode 11)
- decode_valid  input  1  decode holds a real instruction
- flush  input  1  branch taken: squash instruction in decode
- mem_wait  input  1  memory not ready: whole pipeline frozen
- stall  output  1  hold PC and IF/ID, insert bubble into ID/EX
- issue  output  1  instruction advances into EX this cycle
- busy_mask  output  2^REG_AW  bit r = register r has a pending write

Behaviour:
- Operand classes by opcode:
  - 0: nop, no reads, no write.
  - 1-8: reads r1 and r2, writes w.
  - 9 (imm ALU) and 10 (load): read r1, write w.
  - 11 (store): reads r1 and w, no write.
  - 12 (branch): reads r1, no write.
  - 13-15: no reads, no write.
- Register file: cnt[r], CNT_W bits, r = 1..2^REG_AW-1. cnt[0] is constant 0.
- hazard = any read operand with address != 0 and cnt[addr] != 0. Unread fields are ignored.
- Combinational outputs:
  - stall = decode_valid & hazard & !flush.
  - issue = decode_valid & !hazard & !flush & !mem_wait.
- Counter update on each rising edge:
  - rst_n=0: all cnt cleared.
  - mem_wait=1: all cnt hold; issue is 0.
  - Otherwise every nonzero cnt decrements by 1.
  - If issue=1, the opcode writes, and w_decode != 0, then cnt[w_decode] loads WB_DIST. The load overrides the decrement for that register in the same cycle.
- busy_mask[r] = (cnt[r] != 0); bit 0 is always 0.
- Decode sees old state: when w_decode equals a source, the hazard check uses pre-issue counters, so there is no self-stall.
- Flush: no issue, no scoreboard load. Already-issued instructions keep counting (not cancelled).
- Stall with mem_wait: stall still asserts if hazard; counters frozen, so the stall extends by the wait length.
- Reset mid-operation: all pending writes are dropped. While rst_n=0, stall=0 and issue=0 regardless of inputs. After reset: busy_mask=0, stall=0.
- No latency on stall/issue: same cycle as decode inputs. busy_mask changes one edge after issue.

Optional Feature:
- Macro SCOREBOARD_STATS_EN.
- Defined:
  - Adds output stall_cycles [15:0], reset to 0 by rst_n.
  - Increments on every clock where stall=1.
  - Saturates at 16'hFFFF (no wrap).
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: issue writes to r3,r5, then rst_n=0 for 2 cycles -> busy_mask=0, stall=0, issue=0 during and after reset.
2. RAW: cycle 0 opcode 1 w=3 issues (WB_DIST=3); cycle 1 opcode 2 r1=3 valid -> stall=1 cycles 1-3, busy_mask[3]=1 cycles 1-3, issue=1 cycle 4.
3. R0 immunity: opcode 1 w=0 issues, next opcode 1 r1=0 r2=0 -> busy_mask stays 0, no stall, issue=1.
4. Freeze: opcode 10 w=5 issues; mem_wait=1 for 2 cycles starting next cycle -> busy_mask[5] stays set 5 cycles total instead of 3; dependent opcode 9 r1=5 stalls throughout.
5. Flush: opcode 1 w=4 with decode_valid=1 and flush=1 -> issue=0, stall=0, busy_mask[4] stays 0 next cycle.
6. Operand classes: w=2 pending:
   - opcode 11 w=2 -> stall=1.
   - opcode 12 r1=1 r2=2 -> stall=0, issue=1 (r2 ignored).
   - opcode 13 r1=2 -> stall=0.
